// File: rtl/group_route_arbiter_if.sv
// Bundles the source-side and destination-side beat buses of one group's route arbiter.
// The arbiter connects through the slave modport, and the driving environment connects through the master modport.
// Carries no state or clock; handshakes are valid/ready per source and per destination.
interface group_route_arbiter_if #(
    parameter int WIDTH = 320,
    parameter int CNT_W = 16
);
    logic [3:0]         in_valid;
    logic [7:0]         in_dst;
    logic [3:0]         in_last;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic [3:0]         out_valid;
    logic [7:0]         out_sel;
    logic [3:0]         out_last;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_ready;
    logic [4*CNT_W-1:0] stat_conflicts;

    // Upstream SMs and downstream crossbar side
    modport master (
        output in_valid, in_dst, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_sel, out_last, out_data, stat_conflicts
    );

    // Arbiter side
    modport slave (
        input  in_valid, in_dst, in_last, in_data, out_ready,
        output in_ready, out_valid, out_sel, out_last, out_data, stat_conflicts
    );
endinterface

// File: rtl/group_route_arbiter.sv
// Routes beats from 4 SMs to 4 destination slots with per-destination packet-locked round-robin.
// Latency: 1 cycle from an input transfer to out_valid. Each slot refills in the same cycle it drains, so there are no bubbles.
// Backpressure: out_ready low stalls the slot and deasserts in_ready in the same cycle. Define ARB_STATS_EN to build the conflict counters.
module group_route_arbiter #(
    parameter int WIDTH = 320,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    group_route_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Per-destination arbitration state
    lock_state_t      state_q  [4];
    lock_state_t      state_d  [4];
    logic [1:0]       owner_q  [4];
    logic [1:0]       owner_d  [4];
    logic [1:0]       rr_ptr_q [4];
    logic [1:0]       rr_ptr_d [4];

    // Per-destination output slot
    logic [3:0]       out_valid_q;
    logic [3:0]       out_last_q;
    logic [1:0]       out_sel_q  [4];
    logic [WIDTH-1:0] out_data_q [4];

    // Arbitration results
    logic [3:0]       cand [4];     // cand[d][s]: source s requests destination d
    logic [3:0]       slot_free;
    logic [3:0]       grant;
    logic [1:0]       winner [4];
    logic [3:0]       ready;
    logic [WIDTH-1:0] in_beat [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lanes
            assign in_beat[g]                          = bus.in_data[WIDTH*g +: WIDTH];
            assign bus.out_data[WIDTH*g +: WIDTH]      = out_data_q[g];
            assign bus.out_sel[2*g +: 2]               = out_sel_q[g];
        end
    endgenerate

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.in_ready  = ready;

    // Candidate matrix and free-slot flags. A slot is free when it is empty or is draining this cycle.
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            cand[d]      = '0;
            slot_free[d] = !out_valid_q[d] || bus.out_ready[d];
            for (int s = 0; s < 4; s++) begin
                cand[d][s] = bus.in_valid[s] && (bus.in_dst[2*s +: 2] == 2'(d));
            end
        end
    end

    // Per-destination lock FSM next state, winner selection and source ready fan-in
    always_comb begin
        logic [1:0] idx;
        idx   = '0;
        grant = '0;
        ready = '0;
        for (int d = 0; d < 4; d++) begin
            state_d[d]  = state_q[d];
            owner_d[d]  = owner_q[d];
            rr_ptr_d[d] = rr_ptr_q[d];
            winner[d]   = rr_ptr_q[d];
            case (state_q[d])
                IDLE: begin
                    // Scan from the farthest offset down, so that the candidate
                    // closest to rr_ptr is the last one written and therefore wins.
                    for (int k = 3; k >= 0; k--) begin
                        idx = rr_ptr_q[d] + 2'(k);
                        if (cand[d][idx]) begin
                            winner[d] = idx;
                        end
                    end
                    if ((|cand[d]) && slot_free[d]) begin
                        grant[d]    = 1'b1;
                        rr_ptr_d[d] = winner[d] + 2'd1;
                        if (!bus.in_last[winner[d]]) begin
                            state_d[d] = LOCKED;
                            owner_d[d] = winner[d];
                        end
                    end
                end
                default: begin
                    // Locked: only the owner can move. While it is idle, the slot just drains.
                    winner[d] = owner_q[d];
                    if (cand[d][owner_q[d]] && slot_free[d]) begin
                        grant[d]    = 1'b1;
                        rr_ptr_d[d] = owner_q[d] + 2'd1;
                        if (bus.in_last[owner_q[d]]) begin
                            state_d[d] = IDLE;
                        end
                    end
                end
            endcase
            if (grant[d]) begin
                ready[winner[d]] = 1'b1;
            end
        end
    end

    // Lock state, owner and round-robin pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 4; d++) begin
                state_q[d]  <= IDLE;
                owner_q[d]  <= '0;
                rr_ptr_q[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                state_q[d]  <= state_d[d];
                owner_q[d]  <= owner_d[d];
                rr_ptr_q[d] <= rr_ptr_d[d];
            end
        end
    end

    // Output slots: load on grant, clear valid on a drain with no refill, otherwise hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= '0;
            out_last_q  <= '0;
            for (int d = 0; d < 4; d++) begin
                out_sel_q[d]  <= '0;
                out_data_q[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (grant[d]) begin
                    out_valid_q[d] <= 1'b1;
                    out_last_q[d]  <= bus.in_last[winner[d]];
                    out_sel_q[d]   <= winner[d];
                    out_data_q[d]  <= in_beat[winner[d]];
                end else if (bus.out_ready[d]) begin
                    out_valid_q[d] <= 1'b0;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [3:0]       conflict;
    logic [CNT_W-1:0] cnt_q [4];

    // A conflict is an idle destination with a free slot and at least two requesters
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            conflict[d] = (state_q[d] == IDLE) && ($countones(cand[d]) > 1) && slot_free[d];
        end
    end

    // Saturating conflict counters, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 4; d++) begin
                cnt_q[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (conflict[d] && (cnt_q[d] != {CNT_W{1'b1}})) begin
                    cnt_q[d] <= cnt_q[d] + CNT_W'(1);
                end
            end
        end
    end

    generate
        for (g = 0; g < 4; g++) begin : g_stats
            assign bus.stat_conflicts[CNT_W*g +: CNT_W] = cnt_q[g];
        end
    endgenerate
`else
    assign bus.stat_conflicts = {(4*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_group_route_arbiter.sv
// Directed bench for group_route_arbiter: reset, lock, round-robin, backpressure and parallel routing.
// Inputs change on the falling edge. in_ready is sampled before the rising edge, and registered outputs 1ns after it.
// Conflict-counter expectations follow ARB_STATS_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_group_route_arbiter;
    localparam int WIDTH = 320;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    group_route_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    group_route_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle_all();
        bus.in_valid = '0;
        bus.in_dst   = '0;
        bus.in_last  = '0;
        bus.in_data  = '0;
    endtask

    task automatic set_src(input int s, input logic v, input logic [1:0] dst,
                           input logic last, input logic [WIDTH-1:0] data);
        bus.in_valid[s]              = v;
        bus.in_dst[2*s +: 2]         = dst;
        bus.in_last[s]               = last;
        bus.in_data[WIDTH*s +: WIDTH] = data;
    endtask

    function automatic logic [1:0] sel_of(input int d);
        return bus.out_sel[2*d +: 2];
    endfunction

    function automatic logic [WIDTH-1:0] data_of(input int d);
        return bus.out_data[WIDTH*d +: WIDTH];
    endfunction

    function automatic logic [CNT_W-1:0] stat_of(input int d);
        return bus.stat_conflicts[CNT_W*d +: CNT_W];
    endfunction

    task automatic test_reset();
        idle_all();
        bus.out_ready = 4'hF;
        #2;
        total++;
        if ({bus.out_valid, bus.out_last, bus.out_sel} !== 16'h0) begin
            bad++;
            $display("FAIL reset_ctrl got=%h exp=0", {bus.out_valid, bus.out_last, bus.out_sel});
        end
        total++;
        if (bus.out_data !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", bus.out_data);
        end
        total++;
        if (bus.stat_conflicts !== '0 || bus.in_ready !== 4'h0) begin
            bad++;
            $display("FAIL reset_stat_ready stat=%h ready=%b exp 0", bus.stat_conflicts, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        idle_all();
        set_src(0, 1'b1, 2'd2, 1'b0, 'h1);
        #2;
        total++;
        if (bus.in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_first_ready got=%b exp=0001", bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid[2] !== 1'b1 || sel_of(2) !== 2'd0) begin
            bad++;
            $display("FAIL midrst_first_load valid=%b sel=%0d exp 1/0", bus.out_valid[2], sel_of(2));
        end
        @(negedge clk);
        set_src(0, 1'b1, 2'd2, 1'b0, 'h2);
        set_src(1, 1'b1, 2'd2, 1'b1, 'h77);
        #1;
        total++;
        if (bus.in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_locked_ready got=%b exp=0001", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 4'h0 || bus.out_sel !== 8'h0) begin
            bad++;
            $display("FAIL midrst_async valid=%b sel=%h exp 0/0", bus.out_valid, bus.out_sel);
        end
        #1;
        rst = 1'b1;
        idle_all();
        set_src(1, 1'b1, 2'd2, 1'b1, 'h77);
        #1;
        total++;
        if (bus.in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL midrst_after_ready got=%b exp=0010", bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid[2] !== 1'b1 || sel_of(2) !== 2'd1 || data_of(2) !== WIDTH'('h77)) begin
            bad++;
            $display("FAIL midrst_after_load valid=%b sel=%0d data=%h exp 1/1/77",
                     bus.out_valid[2], sel_of(2), data_of(2));
        end
    endtask

    task automatic test_single_beat();
        @(negedge clk);
        idle_all();
        set_src(1, 1'b1, 2'd3, 1'b1, 'hA5);
        #2;
        total++;
        if (bus.in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL single_ready got=%b exp=0010", bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 4'b1000 || sel_of(3) !== 2'd1 || data_of(3) !== WIDTH'('hA5) ||
            bus.out_last[3] !== 1'b1) begin
            bad++;
            $display("FAIL single_load valid=%b sel=%0d data=%h last=%b exp 1000/1/a5/1",
                     bus.out_valid, sel_of(3), data_of(3), bus.out_last[3]);
        end
        @(negedge clk);
        idle_all();
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 4'h0 || sel_of(3) !== 2'd1 || data_of(3) !== WIDTH'('hA5)) begin
            bad++;
            $display("FAIL single_drain valid=%b sel=%0d data=%h exp 0/1/a5",
                     bus.out_valid, sel_of(3), data_of(3));
        end
    endtask

    task automatic test_rr_fairness();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                for (int s = 0; s < 4; s++) set_src(s, 1'b1, 2'd0, 1'b1, WIDTH'(32'h10 + s));
            end
            #2;
            total++;
            if (bus.in_ready !== 4'(1 << (k % 4))) begin
                bad++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.in_ready, 4'(1 << (k % 4)));
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid[0] !== 1'b1 || sel_of(0) !== 2'(k % 4) ||
                data_of(0) !== WIDTH'(32'h10 + (k % 4))) begin
                bad++;
                $display("FAIL rr_out[%0d] valid=%b sel=%0d data=%h exp 1/%0d", k,
                         bus.out_valid[0], sel_of(0), data_of(0), k % 4);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [3:0] exp_rdy [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
        logic [1:0] exp_sel [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
        logic [7:0] exp_dat [4] = '{8'h20, 8'h21, 8'h22, 8'h0A};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            case (k)
                0: begin idle_all(); set_src(2, 1'b1, 2'd1, 1'b0, 'h20); end
                1: begin set_src(2, 1'b1, 2'd1, 1'b0, 'h21); set_src(0, 1'b1, 2'd1, 1'b1, 'h0A); end
                2: set_src(2, 1'b1, 2'd1, 1'b1, 'h22);
                default: set_src(2, 1'b0, 2'd0, 1'b0, '0);
            endcase
            #2;
            total++;
            if (bus.in_ready !== exp_rdy[k]) begin
                bad++;
                $display("FAIL lock_ready[%0d] got=%b exp=%b", k, bus.in_ready, exp_rdy[k]);
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid[1] !== 1'b1 || sel_of(1) !== exp_sel[k] || data_of(1) !== WIDTH'(exp_dat[k])) begin
                bad++;
                $display("FAIL lock_out[%0d] valid=%b sel=%0d data=%h exp 1/%0d/%h", k,
                         bus.out_valid[1], sel_of(1), data_of(1), exp_sel[k], exp_dat[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        idle_all();
        set_src(3, 1'b1, 2'd0, 1'b1, 'h33);
        #2;
        total++;
        if (bus.in_ready !== 4'b1000) begin
            bad++;
            $display("FAIL bp_first_ready got=%b exp=1000", bus.in_ready);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                idle_all();
                set_src(1, 1'b1, 2'd0, 1'b1, 'h11);
                bus.out_ready[0] = 1'b0;
            end
            #2;
            total++;
            if (bus.in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", k, bus.in_ready);
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid[0] !== 1'b1 || sel_of(0) !== 2'd3 || data_of(0) !== WIDTH'('h33) ||
                bus.out_last[0] !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d] valid=%b sel=%0d data=%h exp 1/3/33", k,
                         bus.out_valid[0], sel_of(0), data_of(0));
            end
        end
        @(negedge clk);
        bus.out_ready[0] = 1'b1;
        #2;
        total++;
        if (bus.in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_release_ready got=%b exp=0010", bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid[0] !== 1'b1 || sel_of(0) !== 2'd1 || data_of(0) !== WIDTH'('h11)) begin
            bad++;
            $display("FAIL bp_refill valid=%b sel=%0d data=%h exp 1/1/11",
                     bus.out_valid[0], sel_of(0), data_of(0));
        end
        @(negedge clk);
        idle_all();
        @(posedge clk); #1;
        total++;
        if (bus.out_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain valid=%b exp=0", bus.out_valid[0]);
        end
    endtask

    task automatic test_parallel_stats();
        logic [CNT_W-1:0] exp2;
`ifdef ARB_STATS_EN
        exp2 = CNT_W'(10);
`else
        exp2 = '0;
`endif
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                set_src(0, 1'b1, 2'd1, 1'b1, 'hD1);
                set_src(1, 1'b1, 2'd0, 1'b1, 'hD0);
                set_src(2, 1'b1, 2'd2, 1'b1, 'hC2);
                set_src(3, 1'b1, 2'd2, 1'b1, 'hC3);
            end
            #2;
            total++;
            if (bus.in_ready !== ((k % 2 == 0) ? 4'b0111 : 4'b1011)) begin
                bad++;
                $display("FAIL par_ready[%0d] got=%b exp=%b", k, bus.in_ready,
                         (k % 2 == 0) ? 4'b0111 : 4'b1011);
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 4'b0111 || sel_of(0) !== 2'd1 || sel_of(1) !== 2'd0 ||
                sel_of(2) !== ((k % 2 == 0) ? 2'd2 : 2'd3)) begin
                bad++;
                $display("FAIL par_out[%0d] valid=%b sel=%h", k, bus.out_valid, bus.out_sel);
            end
        end
        @(negedge clk);
        idle_all();
        #2;
        total++;
        if (stat_of(2) !== exp2) begin
            bad++;
            $display("FAIL stat_d2 got=%0d exp=%0d", stat_of(2), exp2);
        end
        total++;
        if (stat_of(0) !== '0 || stat_of(1) !== '0 || stat_of(3) !== '0) begin
            bad++;
            $display("FAIL stat_others got=%h exp=0", bus.stat_conflicts);
        end
        @(posedge clk); #1;
        total++;
        if (stat_of(2) !== exp2) begin
            bad++;
            $display("FAIL stat_d2_hold got=%0d exp=%0d", stat_of(2), exp2);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_single_beat();
        test_rr_fairness();
        test_packet_lock();
        test_backpressure();
        test_parallel_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
